// File: rtl/fetch_pkg.sv
// Purpose: shared opcodes, FSM state encoding and flag indices for the fetch path.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fetch_pkg;

    localparam logic [3:0] OP_BR   = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Bit positions inside the {N,Z,C} condition flag vector
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DELIVER = 2'd1,
        HALTED  = 2'd2
    } state_t;

endpackage

// File: rtl/branch_predecode.sv
// Purpose: combinational pre-decode of branch/jump/halt from an instruction word and ALU flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller qualifies the outputs with its own handshake.
module branch_predecode
    import fetch_pkg::*;
(
    input  logic [15:0] instr_i,
    input  logic [2:0]  flags_i,
    output logic        branch_taken_o,
    output logic        jump_taken_o,
    output logic [5:0]  branch_imm_o,
    output logic [11:0] jump_imm_o,
    output logic        is_halt_o
);

    logic [3:0] opcode;
    logic [2:0] cond;

    assign opcode = instr_i[15:12];
    assign cond   = instr_i[8:6];

    // Branch is taken when any condition bit selects a set flag; cond 000 can never match
    always_comb begin
        branch_taken_o = (opcode == OP_BR) && (|(cond & flags_i));
        jump_taken_o   = (opcode == OP_JMP);
        is_halt_o      = (opcode == OP_HALT);
        branch_imm_o   = instr_i[5:0];
        jump_imm_o     = instr_i[11:0];
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Purpose: fetch instruction at PC over req/ack, hold it for decode, and drive PC advance on acceptance.
// Latency: min 2 cycles per instruction (1 in FETCH with same-cycle ack, 1 in DELIVER with ready).
// Backpressure: request held until ack; instruction held with valid until decode_ready; halt stops fetching.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk_pi,
    input  logic              reset_n_pi,
    input  logic [ADDR_W-1:0] pc_pi,
    output logic              imem_req_po,
    output logic [ADDR_W-1:0] imem_addr_po,
    input  logic              imem_ack_pi,
    input  logic [15:0]       imem_rdata_pi,
    output logic              instr_valid_po,
    output logic [15:0]       instr_po,
    input  logic              decode_ready_pi,
    input  logic [2:0]        flags_pi,
    output logic              pc_clk_en_po,
    output logic              branch_taken_po,
    output logic [5:0]        branch_immediate_po,
    output logic              jump_taken_po,
    output logic [11:0]       jump_immediate_po,
    output logic              halted_po,
    output logic [CNT_W-1:0]  retired_count_po
);

    state_t             state_q, state_d;
    logic [15:0]        instr_q, instr_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               handshake;

    logic               pd_branch_taken;
    logic               pd_jump_taken;
    logic               pd_is_halt;
    logic [5:0]         pd_branch_imm;
    logic [11:0]        pd_jump_imm;

    branch_predecode u_predecode (
        .instr_i        (instr_q),
        .flags_i        (flags_pi),
        .branch_taken_o (pd_branch_taken),
        .jump_taken_o   (pd_jump_taken),
        .branch_imm_o   (pd_branch_imm),
        .jump_imm_o     (pd_jump_imm),
        .is_halt_o      (pd_is_halt)
    );

    // State, latched instruction and retired counter; reset aborts any in-flight fetch
    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            state_q   <= FETCH;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    // Next-state, instruction capture, counter update and handshake detection
    always_comb begin
        state_d        = state_q;
        instr_d        = instr_q;
        retired_d      = retired_q;
        imem_req_po    = 1'b0;
        instr_valid_po = 1'b0;
        halted_po      = 1'b0;
        handshake      = 1'b0;
        case (state_q)
            FETCH: begin
                // No request while reset is held, even though state already reads FETCH
                imem_req_po = reset_n_pi;
                if (imem_ack_pi) begin
                    instr_d = imem_rdata_pi;
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                instr_valid_po = 1'b1;
                if (decode_ready_pi) begin
                    handshake = 1'b1;
                    if (retired_q != {CNT_W{1'b1}}) begin
                        retired_d = retired_q + CNT_W'(1);
                    end
                    state_d = pd_is_halt ? HALTED : FETCH;
                end
            end
            HALTED: begin
                halted_po = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // PC enable is forced during reset so the PC's synchronous reset can act
    assign pc_clk_en_po        = ~reset_n_pi | (handshake & ~pd_is_halt);
    assign branch_taken_po     = handshake & pd_branch_taken;
    assign jump_taken_po       = handshake & pd_jump_taken;
    assign branch_immediate_po = pd_branch_imm;
    assign jump_immediate_po   = pd_jump_imm;
    assign imem_addr_po        = pc_pi;
    assign instr_po            = instr_q;
    assign retired_count_po    = retired_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Fetch-side controller that sits between the program counter, instruction memory and the decode stage.
- Fetches the instruction at the current PC over a req/ack memory handshake and holds it for decode under valid/ready.
- On each decode acceptance, pre-decodes branch/jump/halt and drives the program counter's clock enable, branch and jump inputs for exactly one cycle.
- Closes the loop from the fetched instruction back to the PC advance.

Parameters:
- ADDR_W, 16: instruction address width; must equal PC width.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk_pi  in  1  system clock, rising edge.
- reset_n_pi  in  1  reset; asynchronous assert, active-low.
- pc_pi  in  ADDR_W  current PC from the program counter.
- imem_req_po  out  1  fetch request; held until ack.
- imem_addr_po  out  ADDR_W  fetch address.
- imem_ack_pi  in  1  memory ack; data valid this cycle.
- imem_rdata_pi  in  16  fetched instruction word.
- instr_valid_po  out  1  instruction available to decode.
- instr_po  out  16  latched instruction.
- decode_ready_pi  in  1  decode accepts instruction.
- flags_pi  in  3  ALU condition flags {N,Z,C}.
- pc_clk_en_po  out  1  PC clock enable.
- branch_taken_po  out  1  PC branch select.
- branch_immediate_po  out  6  branch offset, raw (the PC sign-extends it).
- jump_taken_po  out  1  PC jump select.
- jump_immediate_po  out  12  jump offset, raw (the PC sign-extends it).
- halted_po  out  1  core halted.
- retired_count_po  out  CNT_W  instructions accepted, saturating.

Behaviour:

Reset (reset_n_pi low):
- Asynchronously clears state to FETCH, instr_po to 0, retired_count_po to 0.
- All registered outputs read 0.
- pc_clk_en_po is forced high combinationally whenever reset_n_pi is low. This is required so the PC's synchronous reset (driven from the inverted system reset) takes effect.
- branch_taken_po and jump_taken_po are 0 during reset.

State FETCH:
- imem_req_po = 1 and imem_addr_po = pc_pi. The address is stable because the PC changes only on an advance edge.
- On imem_ack_pi = 1, latch imem_rdata_pi into instr_po and go to DELIVER.
- Same-cycle ack is legal, giving a minimum of 1 cycle in FETCH.
- The request is never withdrawn before ack.

State DELIVER:
- instr_valid_po = 1 and imem_req_po = 0.
- instr_po is stable until the handshake completes.
- Handshake = instr_valid_po & decode_ready_pi. In the handshake cycle:
  - If opcode (instr[15:12]) == OP_HALT: no PC advance; go to HALTED.
  - Else: pc_clk_en_po = 1 for that cycle only; go to FETCH.
  - OP_BR: cond = instr[8:6]; branch_taken_po = |(cond & flags_pi), evaluated combinationally in the handshake cycle. branch_immediate_po = instr[5:0]. cond = 000 is never taken.
  - OP_JMP: jump_taken_po = 1; jump_immediate_po = instr[11:0].
  - Any other opcode: both taken signals 0, giving a plain PC+2.
  - branch_taken_po and jump_taken_po are mutually exclusive and never high outside a handshake cycle.
  - retired_count_po increments by 1, saturating at all-ones. HALT also counts.

State HALTED:
- All strobes 0; halted_po = 1.
- Exit only via reset.

Outside handshake cycles and reset, pc_clk_en_po = 0.

Throughput: minimum 2 cycles per instruction (FETCH with immediate ack, DELIVER with ready).

Boundaries:
- decode_ready_pi held low: stay in DELIVER indefinitely; no PC change.
- A late ack simply stretches FETCH.
- Reset asserted mid-FETCH or mid-DELIVER: immediate abort to reset state; a pending ack is ignored.
- flags_pi changing while waiting in DELIVER: only the handshake-cycle value matters.

Decomposition:
- Shared package fetch_pkg:
  - Opcode constants OP_BR = 4'hD, OP_JMP = 4'hE, OP_HALT = 4'hF.
  - State enum {FETCH, DELIVER, HALTED}.
  - Flag bit indices N = 2, Z = 1, C = 0.
- One natural sub-module, branch_predecode: combinational; takes instr and flags and returns branch_taken, jump_taken, both immediates and is_halt. It is reused later by the decoder.

Test Plan:
1. Reset release, pc_pi = 0, ack same cycle with rdata = 16'h1234, ready = 1 -> imem_addr_po = 0; instr_po = 16'h1234 next cycle; pc_clk_en_po pulses once with both taken = 0; retired_count_po = 1.
2. instr 16'hD1C5 (cond = 111, imm = 6'h05), flags = 3'b010 -> branch_taken_po = 1, branch_immediate_po = 6'h05 in the handshake cycle. Repeat with flags = 0 -> branch_taken_po = 0, pc_clk_en_po = 1.
3. instr 16'hEFFE -> jump_taken_po = 1, jump_immediate_po = 12'hFFE, branch_taken_po = 0, single-cycle pulse.
4. Ack delayed 5 cycles and decode_ready low 3 cycles -> imem_req_po held 6 cycles; instr_valid_po held; no pc_clk_en_po pulse until ready rises.
5. instr 16'hF000 -> no pc_clk_en_po pulse; halted_po = 1 next cycle; no further imem_req_po for 20 cycles; reset -> FETCH resumes.
6. Assert reset_n_pi low mid-DELIVER -> instr_valid_po = 0 and pc_clk_en_po = 1 immediately (asynchronous); retired_count_po = 0.
